// File: rtl/axi_eth_bridge_pkg.sv
// Shared types and constants for the AXI Ethernet receive bridge.
// The RX_LEN_CHECK_EN build option is consumed by axi_ethernet_rx_bridge.
package axi_eth_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_STATUS = 2'd2,
    ST_REPORT = 2'd3
  } state_t;

  localparam int unsigned AXIS_W        = 32;
  localparam int unsigned KEEP_W        = 4;
  localparam int unsigned LEN_W         = 16;
  localparam int unsigned LEN_ERR_BIT   = 31;
  localparam int unsigned HDR_ERR_BIT   = 30;
  localparam int unsigned SHORT_ERR_BIT = 29;

  localparam logic [3:0] STATUS_FLAG = 4'h5;

  // Single-beat per-frame report word; unused bits stay zero.
  function automatic logic [AXIS_W-1:0] build_report(input logic len_err,
                                                     input logic hdr_err,
                                                     input logic short_err,
                                                     input logic [LEN_W-1:0] length);
    logic [AXIS_W-1:0] r;
    r                = '0;
    r[LEN_ERR_BIT]   = len_err;
    r[HDR_ERR_BIT]   = hdr_err;
    r[SHORT_ERR_BIT] = short_err;
    r[LEN_W-1:0]     = length;
    return r;
  endfunction

endpackage

// File: rtl/rx_byte_counter.sv
// Saturating byte counter: adds popcount(keep) on each accepted data beat.
module rx_byte_counter
  import axi_eth_bridge_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              add_en,
  input  logic [KEEP_W-1:0] keep,
  output logic [LEN_W-1:0]  count
);

  logic [2:0]     bytes_c;
  logic [LEN_W:0] sum_c;

  assign bytes_c = 3'(keep[0]) + 3'(keep[1]) + 3'(keep[2]) + 3'(keep[3]);
  assign sum_c   = (LEN_W+1)'(count) + (LEN_W+1)'(bytes_c);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (add_en) begin
      count <= sum_c[LEN_W] ? '1 : sum_c[LEN_W-1:0];
    end
  end

endmodule

// File: rtl/axi_ethernet_rx_bridge.sv
// Forwards MAC receive data to the DMA, then folds the status frame into a one-beat report.
// Define RX_LEN_CHECK_EN to compare counted data bytes against the reported length.
module axi_ethernet_rx_bridge
  import axi_eth_bridge_pkg::*;
#(
  parameter int unsigned STATUS_WORDS = 6,
  parameter int unsigned LEN_WORD     = 5
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic [AXIS_W-1:0] s_axis_rxd_tdata,
  input  logic [KEEP_W-1:0] s_axis_rxd_tkeep,
  input  logic              s_axis_rxd_tlast,
  input  logic              s_axis_rxd_tvalid,
  output logic              s_axis_rxd_tready,
  input  logic [AXIS_W-1:0] s_axis_rxs_tdata,
  input  logic [KEEP_W-1:0] s_axis_rxs_tkeep,
  input  logic              s_axis_rxs_tlast,
  input  logic              s_axis_rxs_tvalid,
  output logic              s_axis_rxs_tready,
  output logic [AXIS_W-1:0] m_axis_rxd_tdata,
  output logic [KEEP_W-1:0] m_axis_rxd_tkeep,
  output logic              m_axis_rxd_tlast,
  output logic              m_axis_rxd_tvalid,
  input  logic              m_axis_rxd_tready,
  output logic [AXIS_W-1:0] m_axis_rxs_tdata,
  output logic              m_axis_rxs_tvalid,
  output logic              m_axis_rxs_tlast,
  input  logic              m_axis_rxs_tready
);

  localparam int unsigned CNT_W = (STATUS_WORDS > 1) ? $clog2(STATUS_WORDS) : 1;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   beat_cnt;
  logic               hdr_err, short_err;
  logic [LEN_W-1:0]   length;
  logic               len_err_c;
  logic               pass_c, data_acc_c, sts_acc_c, sts_last_beat_c, sts_end_c, rpt_done_c;
  logic               unused_bits;

  assign pass_c          = !areset && (state == ST_IDLE || state == ST_DATA);
  assign data_acc_c      = pass_c && s_axis_rxd_tvalid && m_axis_rxd_tready;
  assign sts_acc_c       = !areset && (state == ST_STATUS) && s_axis_rxs_tvalid;
  assign sts_last_beat_c = (beat_cnt == CNT_W'(STATUS_WORDS - 1));
  assign sts_end_c       = sts_acc_c && (sts_last_beat_c || s_axis_rxs_tlast);
  assign rpt_done_c      = !areset && (state == ST_REPORT) && m_axis_rxs_tready;
  assign m_axis_rxs_tlast = m_axis_rxs_tvalid;
  assign unused_bits     = &{1'b0, s_axis_rxs_tkeep, s_axis_rxs_tdata[27:16]};

`ifdef RX_LEN_CHECK_EN
  logic [LEN_W-1:0] byte_count;

  rx_byte_counter u_byte_counter (
    .clk    (aclk),
    .rst    (areset),
    .clr    (rpt_done_c),
    .add_en (data_acc_c),
    .keep   (s_axis_rxd_tkeep),
    .count  (byte_count)
  );

  assign len_err_c = (byte_count != length);
`else
  assign len_err_c = 1'b0;
`endif

  always_ff @(posedge aclk) begin
    if (areset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and all handshake/pass-through outputs; everything is gated off in reset.
  always_comb begin
    state_nxt         = state;
    s_axis_rxd_tready = 1'b0;
    m_axis_rxd_tvalid = 1'b0;
    m_axis_rxd_tdata  = '0;
    m_axis_rxd_tkeep  = '0;
    m_axis_rxd_tlast  = 1'b0;
    s_axis_rxs_tready = 1'b0;
    m_axis_rxs_tvalid = 1'b0;
    m_axis_rxs_tdata  = '0;
    if (!areset) begin
      m_axis_rxd_tdata = s_axis_rxd_tdata;
      m_axis_rxd_tkeep = s_axis_rxd_tkeep;
      m_axis_rxd_tlast = s_axis_rxd_tlast;
      case (state)
        ST_IDLE, ST_DATA: begin
          m_axis_rxd_tvalid = s_axis_rxd_tvalid;
          s_axis_rxd_tready = m_axis_rxd_tready;
          if (data_acc_c) begin
            state_nxt = s_axis_rxd_tlast ? ST_STATUS : ST_DATA;
          end
        end
        ST_STATUS: begin
          s_axis_rxs_tready = 1'b1;
          if (sts_end_c) begin
            state_nxt = ST_REPORT;
          end
        end
        ST_REPORT: begin
          m_axis_rxs_tvalid = 1'b1;
          m_axis_rxs_tdata  = build_report(len_err_c, hdr_err, short_err, length);
          if (m_axis_rxs_tready) begin
            state_nxt = ST_IDLE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Status frame capture; held stable through REPORT and cleared on the report handshake.
  always_ff @(posedge aclk) begin
    if (areset || rpt_done_c) begin
      beat_cnt  <= '0;
      hdr_err   <= 1'b0;
      short_err <= 1'b0;
      length    <= '0;
    end else if (sts_acc_c) begin
      if (beat_cnt == '0 && s_axis_rxs_tdata[31:28] != STATUS_FLAG) begin
        hdr_err <= 1'b1;
      end
      if (beat_cnt == CNT_W'(LEN_WORD)) begin
        length <= s_axis_rxs_tdata[LEN_W-1:0];
      end
      if (sts_end_c) begin
        short_err <= !sts_last_beat_c;
      end else begin
        beat_cnt <= beat_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_axi_ethernet_rx_bridge.sv
// Directed self-checking bench for axi_ethernet_rx_bridge (default and RX_LEN_CHECK_EN builds).
module tb_axi_ethernet_rx_bridge;

  logic        aclk = 1'b0;
  logic        areset;
  logic [31:0] s_axis_rxd_tdata;
  logic [3:0]  s_axis_rxd_tkeep;
  logic        s_axis_rxd_tlast;
  logic        s_axis_rxd_tvalid;
  logic        s_axis_rxd_tready;
  logic [31:0] s_axis_rxs_tdata;
  logic [3:0]  s_axis_rxs_tkeep;
  logic        s_axis_rxs_tlast;
  logic        s_axis_rxs_tvalid;
  logic        s_axis_rxs_tready;
  logic [31:0] m_axis_rxd_tdata;
  logic [3:0]  m_axis_rxd_tkeep;
  logic        m_axis_rxd_tlast;
  logic        m_axis_rxd_tvalid;
  logic        m_axis_rxd_tready;
  logic [31:0] m_axis_rxs_tdata;
  logic        m_axis_rxs_tvalid;
  logic        m_axis_rxs_tlast;
  logic        m_axis_rxs_tready;

  int checks   = 0;
  int failures = 0;

  always #5 aclk = ~aclk;

  axi_ethernet_rx_bridge dut (
    .aclk              (aclk),
    .areset            (areset),
    .s_axis_rxd_tdata  (s_axis_rxd_tdata),
    .s_axis_rxd_tkeep  (s_axis_rxd_tkeep),
    .s_axis_rxd_tlast  (s_axis_rxd_tlast),
    .s_axis_rxd_tvalid (s_axis_rxd_tvalid),
    .s_axis_rxd_tready (s_axis_rxd_tready),
    .s_axis_rxs_tdata  (s_axis_rxs_tdata),
    .s_axis_rxs_tkeep  (s_axis_rxs_tkeep),
    .s_axis_rxs_tlast  (s_axis_rxs_tlast),
    .s_axis_rxs_tvalid (s_axis_rxs_tvalid),
    .s_axis_rxs_tready (s_axis_rxs_tready),
    .m_axis_rxd_tdata  (m_axis_rxd_tdata),
    .m_axis_rxd_tkeep  (m_axis_rxd_tkeep),
    .m_axis_rxd_tlast  (m_axis_rxd_tlast),
    .m_axis_rxd_tvalid (m_axis_rxd_tvalid),
    .m_axis_rxd_tready (m_axis_rxd_tready),
    .m_axis_rxs_tdata  (m_axis_rxs_tdata),
    .m_axis_rxs_tvalid (m_axis_rxs_tvalid),
    .m_axis_rxs_tlast  (m_axis_rxs_tlast),
    .m_axis_rxs_tready (m_axis_rxs_tready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Present one data beat, wait (bounded) for acceptance, check the zero-latency forward.
  task automatic put_data(input logic [31:0] d, input logic [3:0] k, input logic l);
    int n = 0;
    s_axis_rxd_tdata  = d;
    s_axis_rxd_tkeep  = k;
    s_axis_rxd_tlast  = l;
    s_axis_rxd_tvalid = 1'b1;
    #1;
    while (!s_axis_rxd_tready && n < 20) begin
      tick();
      n++;
    end
    chk("rxd_tready", 32'(s_axis_rxd_tready), 32'd1);
    chk("rxd_fwd_valid", 32'(m_axis_rxd_tvalid), 32'd1);
    chk("rxd_fwd_data", m_axis_rxd_tdata, d);
    chk("rxd_fwd_keep", 32'(m_axis_rxd_tkeep), 32'(k));
    chk("rxd_fwd_last", 32'(m_axis_rxd_tlast), 32'(l));
    tick();
    s_axis_rxd_tvalid = 1'b0;
    s_axis_rxd_tlast  = 1'b0;
  endtask

  task automatic put_sts(input logic [31:0] w, input logic l);
    int n = 0;
    s_axis_rxs_tdata  = w;
    s_axis_rxs_tlast  = l;
    s_axis_rxs_tvalid = 1'b1;
    #1;
    while (!s_axis_rxs_tready && n < 20) begin
      tick();
      n++;
    end
    chk("rxs_tready", 32'(s_axis_rxs_tready), 32'd1);
    tick();
    s_axis_rxs_tvalid = 1'b0;
    s_axis_rxs_tlast  = 1'b0;
  endtask

  task automatic get_rpt(input string tag, input logic [31:0] exp);
    int n = 0;
    while (!m_axis_rxs_tvalid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, 32'(m_axis_rxs_tvalid), 32'd1);
    chk({tag, "_data"}, m_axis_rxs_tdata, exp);
    chk({tag, "_last"}, 32'(m_axis_rxs_tlast), 32'd1);
    m_axis_rxs_tready = 1'b1;
    tick();
    m_axis_rxs_tready = 1'b0;
    #1;
    chk({tag, "_done"}, 32'(m_axis_rxs_tvalid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] exp_w;
    areset            = 1'b1;
    s_axis_rxd_tdata  = 32'h1234_5678;
    s_axis_rxd_tkeep  = 4'hF;
    s_axis_rxd_tlast  = 1'b0;
    s_axis_rxd_tvalid = 1'b1;
    s_axis_rxs_tdata  = '0;
    s_axis_rxs_tkeep  = 4'hF;
    s_axis_rxs_tlast  = 1'b0;
    s_axis_rxs_tvalid = 1'b1;
    m_axis_rxd_tready = 1'b1;
    m_axis_rxs_tready = 1'b0;
    tick();
    tick();
    // Reset gating with traffic presented
    chk("rst_rxd_tvalid", 32'(m_axis_rxd_tvalid), 32'd0);
    chk("rst_rxd_tready", 32'(s_axis_rxd_tready), 32'd0);
    chk("rst_rxd_tdata", m_axis_rxd_tdata, 32'd0);
    chk("rst_rxs_tready", 32'(s_axis_rxs_tready), 32'd0);
    chk("rst_rpt_valid", 32'(m_axis_rxs_tvalid), 32'd0);
    chk("rst_rpt_data", m_axis_rxs_tdata, 32'd0);
    s_axis_rxd_tvalid = 1'b0;
    s_axis_rxs_tvalid = 1'b0;
    areset = 1'b0;
    tick();

    // Frame 1: two full beats; status presented early must be back-pressured
    s_axis_rxs_tdata  = 32'h5000_0000;
    s_axis_rxs_tvalid = 1'b1;
    #1;
    chk("early_sts_idle", 32'(s_axis_rxs_tready), 32'd0);
    put_data(32'h0c05_fefe, 4'hF, 1'b0);
    chk("early_sts_data", 32'(s_axis_rxs_tready), 32'd0);
    put_data(32'h00ba_baca, 4'hF, 1'b1);
    put_sts(32'h5000_0000, 1'b0);
    for (int i = 0; i < 4; i++) put_sts(32'h0, 1'b0);
    put_sts(32'h0000_0008, 1'b1);
    // Report held 5 cycles with data path stalled
    s_axis_rxd_tvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 32'(m_axis_rxs_tvalid), 32'd1);
      chk("stall_data", m_axis_rxs_tdata, 32'h0000_0008);
      chk("stall_rxd_tready", 32'(s_axis_rxd_tready), 32'd0);
      chk("stall_rxd_tvalid", 32'(m_axis_rxd_tvalid), 32'd0);
      tick();
    end
    s_axis_rxd_tvalid = 1'b0;
    get_rpt("rpt1", 32'h0000_0008);
    chk("idle_rxd_tready", 32'(s_axis_rxd_tready), 32'd1);

    // Frame 2: partial last beat (6 bytes), matching length
    put_data(32'h1111_1111, 4'hF, 1'b0);
    put_data(32'h0000_2222, 4'h3, 1'b1);
    put_sts(32'h5000_0000, 1'b0);
    for (int i = 0; i < 4; i++) put_sts(32'h0, 1'b0);
    put_sts(32'h0000_0006, 1'b1);
    get_rpt("rpt_len6", 32'h0000_0006);

    // Frame 3: same 6 bytes, status claims 8
    put_data(32'h1111_1111, 4'hF, 1'b0);
    put_data(32'h0000_2222, 4'h3, 1'b1);
    put_sts(32'h5000_0000, 1'b0);
    for (int i = 0; i < 4; i++) put_sts(32'h0, 1'b0);
    put_sts(32'h0000_0008, 1'b1);
`ifdef RX_LEN_CHECK_EN
    exp_w = 32'h8000_0008;
`else
    exp_w = 32'h0000_0008;
`endif
    get_rpt("rpt_len8", exp_w);

    // Frame 4: single beat, bad header, status ends early on beat 2
    put_data(32'hdead_beef, 4'hF, 1'b1);
    put_sts(32'h4000_0000, 1'b0);
    put_sts(32'h0000_0000, 1'b0);
    put_sts(32'h0000_1234, 1'b1);
`ifdef RX_LEN_CHECK_EN
    exp_w = 32'hE000_0000;
`else
    exp_w = 32'h6000_0000;
`endif
    get_rpt("rpt_short", exp_w);
    // Surplus status beat is not absorbed outside STATUS
    s_axis_rxs_tdata  = 32'h0000_00aa;
    s_axis_rxs_tvalid = 1'b1;
    tick();
    chk("extra_sts_held", 32'(s_axis_rxs_tready), 32'd0);
    s_axis_rxs_tvalid = 1'b0;

    // Reset in the middle of a frame
    put_data(32'haaaa_aaaa, 4'hF, 1'b0);
    areset            = 1'b1;
    s_axis_rxd_tdata  = 32'hbbbb_bbbb;
    s_axis_rxd_tvalid = 1'b1;
    #1;
    chk("mid_rst_rxd_tvalid", 32'(m_axis_rxd_tvalid), 32'd0);
    chk("mid_rst_rxd_tready", 32'(s_axis_rxd_tready), 32'd0);
    chk("mid_rst_rpt_valid", 32'(m_axis_rxs_tvalid), 32'd0);
    tick();
    areset            = 1'b0;
    s_axis_rxd_tvalid = 1'b0;
    put_data(32'hbbbb_bbbb, 4'hF, 1'b1);
    put_sts(32'h5000_0000, 1'b0);
    for (int i = 0; i < 4; i++) put_sts(32'h0, 1'b0);
    put_sts(32'h0000_0004, 1'b1);
    get_rpt("rpt_after_rst", 32'h0000_0004);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_ethernet_rx_bridge.md
AXI_ETHERNET_RX_BRIDGE -- requirements
Module: axi_ethernet_rx_bridge

Interface
REQ-001 STATUS_WORDS, default 6: number of beats in one receive-status frame on s_axis_rxs.
REQ-002 LEN_WORD, default 5: index of the status beat whose bits [15:0] carry the frame length in bytes.
REQ-003 aclk  in  1  single clock; all logic is on its rising edge.
REQ-004 areset  in  1  reset, synchronous, active-high.
REQ-005 s_axis_rxd_tdata  in  32  receive frame data from the MAC.
REQ-006 s_axis_rxd_tkeep  in  4  byte enables for frame data.
REQ-007 s_axis_rxd_tlast  in  1  last beat of frame.
REQ-008 s_axis_rxd_tvalid  in  1  frame data valid.
REQ-009 s_axis_rxd_tready  out  1  frame data accepted.
REQ-010 s_axis_rxs_tdata  in  32  receive-status word from the MAC.
REQ-011 s_axis_rxs_tkeep  in  4  status byte enables; ignored.
REQ-012 s_axis_rxs_tlast  in  1  last status beat.
REQ-013 s_axis_rxs_tvalid  in  1  status valid.
REQ-014 s_axis_rxs_tready  out  1  status accepted.
REQ-015 m_axis_rxd_tdata  out  32  frame data to the DMA.
REQ-016 m_axis_rxd_tkeep  out  4  byte enables to the DMA.
REQ-017 m_axis_rxd_tlast  out  1  last beat to the DMA.
REQ-018 m_axis_rxd_tvalid  out  1  data valid to the DMA.
REQ-019 m_axis_rxd_tready  in  1  DMA ready.
REQ-020 m_axis_rxs_tdata  out  32  per-frame report: [31] len_err, [30] hdr_err, [29] short_err, [28:16] zero, [15:0] length.
REQ-021 m_axis_rxs_tvalid  out  1  report valid; the report is always a single beat.
REQ-022 m_axis_rxs_tlast  out  1  equals m_axis_rxs_tvalid.
REQ-023 m_axis_rxs_tready  in  1  report consumer ready.

Function
REQ-024 FSM states: IDLE, DATA, STATUS, REPORT.
REQ-025 Data path in IDLE/DATA:
- combinational pass-through with zero latency;
- m_axis_rxd_tvalid = s_axis_rxd_tvalid;
- s_axis_rxd_tready = m_axis_rxd_tready;
- tdata, tkeep and tlast are forwarded unchanged.
REQ-026 In STATUS/REPORT: s_axis_rxd_tready=0 and m_axis_rxd_tvalid=0.
REQ-027 Data transitions:
- IDLE goes to DATA on an accepted beat without tlast;
- IDLE or DATA goes to STATUS on an accepted beat with tlast (a single-beat frame goes IDLE->STATUS).
REQ-028 s_axis_rxs_tready=1 only in STATUS, so status arriving before its frame ends is back-pressured.
REQ-029 Status capture:
- a status beat counter runs 0..STATUS_WORDS-1;
- beat 0 with [31:28]!=4'h5 sets hdr_err;
- beat LEN_WORD bits [15:0] are latched as length.
REQ-030 STATUS goes to REPORT on the accepted beat where the counter equals STATUS_WORDS-1, or on an earlier tlast.
REQ-031 An early tlast sets short_err, and length stays 0 if LEN_WORD was not reached.
REQ-032 Extra status beats are not absorbed: the next beat is held in back-pressure until the next STATUS state.
REQ-033 REPORT holds m_axis_rxs_tvalid=1 with stable tdata until m_axis_rxs_tready; the handshake returns the FSM to IDLE and clears all flags, counters and length.
REQ-034 m_axis_rxs_tvalid is 0 outside REPORT.

Reset
REQ-035 During areset:
- state=IDLE;
- all registers are cleared;
- m_axis_rxs_tvalid=0 and m_axis_rxs_tdata=0;
- s_axis_rxs_tready=0;
- the pass-through outputs are gated to 0.
REQ-036 Reset mid-frame discards capture; after release the remainder of the interrupted frame passes through as a new frame.

Configuration
REQ-037 RX_LEN_CHECK_EN defined:
- a 16-bit byte counter adds popcount(s_axis_rxd_tkeep) per accepted data beat;
- the counter saturates at 16'hFFFF;
- len_err=1 in REPORT if the count differs from the latched length.
REQ-038 RX_LEN_CHECK_EN undefined: the counter is absent and len_err is constant 0.

Structure
REQ-039 Shared package axi_eth_bridge_pkg holds:
- the state enum;
- the status flag nibble 4'h5;
- report bit positions 31/30/29;
- the length field width 16.
REQ-040 The byte counter is the one natural sub-module, rx_byte_counter (popcount, saturating accumulate, clear); it is instantiated only under RX_LEN_CHECK_EN.

Verification
REQ-041 2-beat frame (0x0c05fefe, 0x00babaca with tlast, tkeep F/F), status {0x5000_0000, 0,0,0,0, 0x0008} -> data forwarded zero-latency; report 0x0000_0008.
REQ-042 Status valid asserted during the frame -> s_axis_rxs_tready stays 0 until the data tlast beat is accepted.
REQ-043 Last tkeep=4'h3 on 2 beats, status length 6 -> report 0x0000_0006; with length 8 and RX_LEN_CHECK_EN -> 0x8000_0008.
REQ-044 Beat 0=0x4000_0000 and tlast on beat 2 -> report 0x6000_0000.
REQ-045 m_axis_rxs_tready low 5 cycles in REPORT -> tvalid and tdata stable; data path stalled; IDLE after the handshake.
REQ-046 areset pulsed mid-frame -> all outputs reset; the next complete frame and status produce a correct report.
